// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: start handshake, key/datapath selects
// and output strobes of the AES round sequencer.
interface aes_round_sequencer_if #(
  parameter int DW = 8
);
  logic          start;
  logic          ready;
  logic          busy;
  logic          in_req;
  logic          input_sel;
  logic          sbox_sel;
  logic          last_out_sel;
  logic          bit_out_sel;
  logic [DW-1:0] rcon_en;
  logic [1:0]    c3;
  logic [DW-1:0] mc_en;
  logic          pld;
  logic [3:0]    round_idx;
  logic          out_vld;
  logic          out_last;
  logic          done;

  modport master (
    output start,
    input  ready, busy, in_req,
    input  input_sel, sbox_sel,
    input  last_out_sel, bit_out_sel,
    input  rcon_en, c3, mc_en, pld,
    input  round_idx, out_vld,
    input  out_last, done
  );

  modport slave (
    input  start,
    output ready, busy, in_req,
    output input_sel, sbox_sel,
    output last_out_sel, bit_out_sel,
    output rcon_en, c3, mc_en, pld,
    output round_idx, out_vld,
    output out_last, done
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: byte-serial AES control sequencer.
// Load, NUM_ROUNDS key/round phases, then a 16-byte drain.
module aes_round_sequencer #(
  parameter int DW          = 8,
  parameter int NUM_ROUNDS  = 10,
  parameter int BLOCK_BYTES = 16
) (
  input logic clk,
  input logic rst_n,
  aes_round_sequencer_if.slave bus
);

  if (BLOCK_BYTES != 16) begin : g_bb_chk
    $error("BLOCK_BYTES must be 16");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_nr_chk
    $error("NUM_ROUNDS must be 1..15");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, KB1, KB2, KB3, NORM, SHIF, DRAIN
  } state_t;

  localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);
  localparam logic [3:0] NR   = 4'(NUM_ROUNDS);

  state_t        state;
  logic [3:0]    byte_cnt;
  logic [3:0]    round_idx;
  logic [1:0]    c3_q;
  logic [DW-1:0] mc_q;
  logic          pld_q;
  logic          done_q;

  logic          is_round;
  logic [1:0]    c3_nxt;
  logic [DW-1:0] mc_nxt;
  logic          pld_nxt;
  logic          in_mux;
  logic          sbox_mux;
  logic          last_mux;
  logic          bit_mux;
  logic [DW-1:0] rcon;

  // byte_cnt doubles as the byte position within a round
  function automatic state_t round_state(logic [3:0] rb);
    if (rb == 4'd0)       return KB1;
    else if (rb <= 4'd2)  return KB2;
    else if (rb == 4'd3)  return KB3;
    else if (rb <= 4'd11) return NORM;
    else                  return SHIF;
  endfunction

  function automatic logic [1:0] c3_of(logic [3:0] rb);
    case (rb)
      4'd0, 4'd4, 4'd8, 4'd10: return 2'd2;
      4'd1, 4'd5, 4'd6:        return 2'd1;
      4'd2:                    return 2'd0;
      default:                 return 2'd3;
    endcase
  endfunction

  assign is_round = (state != IDLE) &&
                    (state != LOAD) &&
                    (state != DRAIN);

  always_comb begin
    c3_nxt  = 2'h3;
    mc_nxt  = '0;
    pld_nxt = 1'b0;
    if (is_round) begin
      c3_nxt  = c3_of(byte_cnt);
      pld_nxt = &byte_cnt[1:0];
      if (!pld_nxt && round_idx != NR)
        mc_nxt = '1;
    end
  end

  always_comb begin
    in_mux   = 1'b0;
    sbox_mux = 1'b1;
    last_mux = 1'b0;
    bit_mux  = 1'b0;
    rcon     = '0;
    unique case (1'b1)
      (state == KB1): begin
        in_mux  = 1'b1;
        bit_mux = 1'b1;
        rcon    = '1;
      end
      (state == KB2): begin
        in_mux  = 1'b1;
        bit_mux = 1'b1;
      end
      (state == KB3): begin
        in_mux   = 1'b1;
        sbox_mux = 1'b0;
        bit_mux  = 1'b1;
      end
      (state == NORM): begin
        in_mux   = 1'b1;
        sbox_mux = 1'b0;
        last_mux = 1'b1;
        bit_mux  = 1'b1;
      end
      (state == SHIF): begin
        in_mux   = 1'b1;
        sbox_mux = 1'b0;
        last_mux = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      round_idx <= '0;
      c3_q      <= 2'h3;
      mc_q      <= '0;
      pld_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      c3_q   <= c3_nxt;
      mc_q   <= mc_nxt;
      pld_q  <= pld_nxt;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= LOAD;
            byte_cnt  <= '0;
            round_idx <= '0;
          end
        end
        LOAD: begin
          byte_cnt <= byte_cnt + 4'd1;
          if (byte_cnt == LAST) begin
            state     <= KB1;
            round_idx <= 4'd1;
          end
        end
        DRAIN: begin
          byte_cnt <= byte_cnt + 4'd1;
          if (byte_cnt == LAST) begin
            state     <= IDLE;
            round_idx <= '0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          byte_cnt <= byte_cnt + 4'd1;
          if (byte_cnt != LAST) begin
            state <= round_state(byte_cnt + 4'd1);
          end else if (round_idx < NR) begin
            state     <= KB1;
            round_idx <= round_idx + 4'd1;
          end else begin
            state <= DRAIN;
          end
        end
      endcase
    end
  end

  assign bus.ready        = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.in_req       = (state == LOAD);
  assign bus.input_sel    = in_mux;
  assign bus.sbox_sel     = sbox_mux;
  assign bus.last_out_sel = last_mux;
  assign bus.bit_out_sel  = bit_mux;
  assign bus.rcon_en      = rcon;
  assign bus.c3           = c3_q;
  assign bus.mc_en        = mc_q;
  assign bus.pld          = pld_q;
  assign bus.round_idx    = round_idx;
  assign bus.out_vld      = (state == DRAIN);
  assign bus.out_last     = (state == DRAIN) &&
                            (byte_cnt == LAST);
  assign bus.done         = done_q;

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Parametrised successor to the fixed 8-bit AES top-level controller. It sequences a byte-serial AES datapath and key expansion: a start/ready handshake, a 16-byte load phase, NUM_ROUNDS key-schedule/round phases with datapath mux selects, a no-MixColumns final round, and a 16-byte output drain with valid/last strobes. It drives the existing key_expansion and aes_data_path control inputs and replaces the hard-coded round counter and d_vld logic.

Parameters:
DW, 8, datapath byte width; also the width of rcon_en and mc_en.
NUM_ROUNDS, 10, number of AES rounds (10/12/14); legal range 1..15.
BLOCK_BYTES, 16, bytes per block; fixed at 16 and checked at elaboration.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request to begin one block; accepted only when ready=1
ready  out  1  high in IDLE only
busy  out  1  high in every state except IDLE
in_req  out  1  high during LOAD; datapath and key path shift in one byte per cycle
input_sel  out  1  key-path input mux select
sbox_sel  out  1  key-path S-box source select
last_out_sel  out  1  key-path last-output select
bit_out_sel  out  1  key-path bit-out select
rcon_en  out  DW  Rcon enable mask
c3  out  2  ShiftRows tap select, registered
mc_en  out  DW  MixColumns enable mask, registered
pld  out  1  parallel-load strobe, registered
round_idx  out  4  current round: 0 in LOAD, 1..NUM_ROUNDS in the rounds
out_vld  out  1  output byte valid, high during DRAIN
out_last  out  1  high on the 16th DRAIN byte
done  out  1  one-cycle pulse after the last DRAIN byte

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, byte_cnt=0, round_idx=0.
  - All outputs 0 except ready=1, c3=2'h3, sbox_sel=1.
  - Reset asserted mid-operation aborts immediately; there is no done pulse.
- States: IDLE, LOAD, KB1, KB2, KB3, NORM, SHIF, DRAIN. byte_cnt is a 4-bit counter of position within the current phase.
- IDLE: start=1 → LOAD, byte_cnt=0. Otherwise stay. start outside IDLE is ignored.
- LOAD: 16 cycles, in_req=1. On byte_cnt==15 → KB1, round_idx=1.
- Each round is 16 cycles: KB1 ×1, KB2 ×2, KB3 ×1, NORM ×8, SHIF ×4.
- SHIF end:
  - round_idx<NUM_ROUNDS → round_idx+1, KB1.
  - otherwise → DRAIN.
- DRAIN: 16 cycles, out_vld=1, out_last=1 when byte_cnt==15. Then → IDLE with done=1 for exactly one cycle (registered).
- Combinational selects (input_sel, sbox_sel, last_out_sel, bit_out_sel, rcon_en):
  - IDLE/LOAD/DRAIN: 0,1,0,0,0
  - KB1: 1,1,0,1,all-ones
  - KB2: 1,1,0,1,0
  - KB3: 1,0,0,1,0
  - NORM: 1,0,1,1,0
  - SHIF: 1,0,1,0,0
- Round byte position rb (0..15) = offset of the current cycle within the round.
- Registered outputs update one cycle after rb:
  - c3: 3 in IDLE/LOAD/DRAIN. Otherwise, for rb 0..15: 2,1,0,3,2,1,1,3,2,3,2,3,3,3,3,3.
  - mc_en: 0 if rb[1:0]==3, or round_idx==NUM_ROUNDS (final round has no MixColumns), or state is not a round state. Otherwise all-ones.
  - pld: 1 iff in a round state and rb[1:0]==3.
- Latency, start-accept cycle = 0:
  - LOAD cycles 1..16.
  - Rounds cycles 17..16+16·NUM_ROUNDS.
  - DRAIN next 16 cycles.
  - done in the following cycle.
  - NUM_ROUNDS=10: DRAIN 177..192, done at 193.
- Back-to-back: start may be high in the same cycle done pulses. ready is already 1 then, so the block is accepted and LOAD begins the next cycle.
- round_idx never wraps; NUM_ROUNDS ≤ 15 is enforced at elaboration.

Test Plan:
- Reset then idle, no start → ready=1, busy=0, c3=3, mc_en=0, done never asserts for 50 cycles.
- start pulse at cycle 0, NUM_ROUNDS=10 → in_req high exactly cycles 1..16; rcon_en=FF at cycles 17, 33, …, 161; out_vld cycles 177..192; out_last at 192; done one cycle at 193.
- Final-round check, NUM_ROUNDS=10 → mc_en=0 throughout round 10 (cycles 162..177 registered); in rounds 1..9, mc_en=0 only one cycle after rb=3,7,11,15.
- c3/pld sequence within round 1 → c3 = 2,1,0,3,2,1,1,3,2,3,2,3,3,3,3,3 delayed one cycle; pld high one cycle after rb=3,7,11,15.
- rst_n low at cycle 100, mid round 6 → immediate IDLE, ready=1, no done, no out_vld. A new start completes normally in 193 cycles.
- NUM_ROUNDS=14 with start held high continuously → done at 257; next block's LOAD starts at cycle 258; start is ignored while busy.
